// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Program-counter controller for the 16-bit CPU. It owns the PC register and
//   steps it with an up/down incrementer or a full adder. Operations are next,
//   previous, jump, branch, call and return. A small LIFO holds the return
//   addresses. The fetch side and the decode side each use a valid/ready
//   handshake.
//
//   Ports:
//     i_clk          clock, rising edge
//     i_rst          synchronous active-high reset
//     o_pc           current fetch address
//     o_fetch_valid  o_pc is offered to instruction memory
//     i_fetch_ready  memory accepts o_pc this cycle
//     i_op_valid     decode presents an operation
//     o_op_ready     sequencer accepts an operation this cycle
//     i_op           0 NEXT, 1 PREV, 2 JUMP, 3 BRANCH, 4 CALL, 5 RET, 6 HOLD, 7 reserved
//     i_target       absolute address (JUMP/CALL) or signed offset (BRANCH)
//     o_halted       sequencer is in HALT
//     o_stack_err    sticky return-stack overflow/underflow flag
//     o_wrap_trap    sticky NEXT/PREV wrap trap flag
//
//   Optional feature macro: PC_WRAP_TRAP_EN
//     When defined, NEXT at all-ones or PREV at zero halts the sequencer and
//     sets o_wrap_trap. When undefined, these operations wrap silently and
//     o_wrap_trap stays 0.

module pc_sequencer #(
    parameter int               WIDTH       = 16,
    parameter int               STACK_DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_PC    = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    output logic [WIDTH-1:0] o_pc,
    output logic             o_fetch_valid,
    input  logic             i_fetch_ready,
    input  logic             i_op_valid,
    output logic             o_op_ready,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_target,
    output logic             o_halted,
    output logic             o_stack_err,
    output logic             o_wrap_trap
);

    localparam int PTR_W = $clog2(STACK_DEPTH);
    localparam int SP_W  = PTR_W + 1;

    localparam logic [2:0] OP_NEXT   = 3'd0;
    localparam logic [2:0] OP_PREV   = 3'd1;
    localparam logic [2:0] OP_JUMP   = 3'd2;
    localparam logic [2:0] OP_BRANCH = 3'd3;
    localparam logic [2:0] OP_CALL   = 3'd4;
    localparam logic [2:0] OP_RET    = 3'd5;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_DECODE,
        ST_HALT
    } state_t;

    state_t           state;
    logic [SP_W-1:0]  sp;
    logic [WIDTH-1:0] stack_mem [STACK_DEPTH];

    // Datapath helpers. The incrementer counts up for everything except
    // PREV, so CALL reuses it to form the return address pc+1.
    logic             inc_up;
    logic [WIDTH-1:0] inc_result;
    logic [WIDTH-1:0] add_result;
    logic [PTR_W-1:0] push_idx;
    logic [PTR_W-1:0] top_idx;
    logic             stack_full;
    logic             stack_empty;
    logic             wrap_hit;

    assign inc_up      = (i_op != OP_PREV);
    assign inc_result  = inc_up ? (o_pc + ONE) : (o_pc - ONE);
    assign add_result  = o_pc + i_target;
    assign push_idx    = sp[PTR_W-1:0];
    assign top_idx     = sp[PTR_W-1:0] - PTR_W'(1);
    assign stack_full  = (sp == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp == '0);

`ifdef PC_WRAP_TRAP_EN
    // A NEXT from all-ones or a PREV from zero would leave the address space.
    assign wrap_hit = ((i_op == OP_NEXT) && (&o_pc)) ||
                      ((i_op == OP_PREV) && (o_pc == '0));
`else
    assign wrap_hit = 1'b0;
`endif

    // Sequencer FSM with registered handshake and status outputs. In DECODE,
    // an accepted op defaults to a return to FETCH. The error branches then
    // override that default and park the sequencer in HALT.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= ST_FETCH;
            o_pc          <= RESET_PC;
            sp            <= '0;
            o_stack_err   <= 1'b0;
            o_wrap_trap   <= 1'b0;
            o_halted      <= 1'b0;
            o_fetch_valid <= 1'b1;
            o_op_ready    <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (i_fetch_ready) begin
                        state         <= ST_DECODE;
                        o_fetch_valid <= 1'b0;
                        o_op_ready    <= 1'b1;
                    end
                end

                ST_DECODE: begin
                    if (i_op_valid) begin
                        state         <= ST_FETCH;
                        o_fetch_valid <= 1'b1;
                        o_op_ready    <= 1'b0;
                        case (i_op)
                            OP_NEXT, OP_PREV: begin
                                if (wrap_hit) begin
                                    o_wrap_trap   <= 1'b1;
                                    state         <= ST_HALT;
                                    o_halted      <= 1'b1;
                                    o_fetch_valid <= 1'b0;
                                end else begin
                                    o_pc <= inc_result;
                                end
                            end
                            OP_JUMP:   o_pc <= i_target;
                            OP_BRANCH: o_pc <= add_result;
                            OP_CALL: begin
                                if (stack_full) begin
                                    o_stack_err   <= 1'b1;
                                    state         <= ST_HALT;
                                    o_halted      <= 1'b1;
                                    o_fetch_valid <= 1'b0;
                                end else begin
                                    stack_mem[push_idx] <= inc_result;
                                    sp                  <= sp + SP_W'(1);
                                    o_pc                <= i_target;
                                end
                            end
                            OP_RET: begin
                                if (stack_empty) begin
                                    o_stack_err   <= 1'b1;
                                    state         <= ST_HALT;
                                    o_halted      <= 1'b1;
                                    o_fetch_valid <= 1'b0;
                                end else begin
                                    o_pc <= stack_mem[top_idx];
                                    sp   <= sp - SP_W'(1);
                                end
                            end
                            default: o_pc <= o_pc;
                        endcase
                    end
                end

                default: begin
                    state         <= ST_HALT;
                    o_halted      <= 1'b1;
                    o_fetch_valid <= 1'b0;
                    o_op_ready    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
//   Directed testbench for pc_sequencer with hand-computed expected values.
//   It covers fetch stalls, stepping, branches, call/return nesting, stack
//   overflow and underflow, wrap behaviour and reset during a handshake.
//   Build with +define+PC_WRAP_TRAP_EN to exercise the trapping variant.

module tb_pc_sequencer;

    localparam logic [2:0] OP_NEXT   = 3'd0;
    localparam logic [2:0] OP_PREV   = 3'd1;
    localparam logic [2:0] OP_JUMP   = 3'd2;
    localparam logic [2:0] OP_BRANCH = 3'd3;
    localparam logic [2:0] OP_CALL   = 3'd4;
    localparam logic [2:0] OP_RET    = 3'd5;
    localparam logic [2:0] OP_HOLD   = 3'd6;
    localparam logic [2:0] OP_RSVD   = 3'd7;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic [15:0] o_pc;
    logic        o_fetch_valid;
    logic        i_fetch_ready = 1'b0;
    logic        i_op_valid = 1'b0;
    logic        o_op_ready;
    logic [2:0]  i_op = 3'd0;
    logic [15:0] i_target = 16'h0000;
    logic        o_halted;
    logic        o_stack_err;
    logic        o_wrap_trap;

    int test_count = 0;
    int fail_count = 0;

    pc_sequencer dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .o_pc          (o_pc),
        .o_fetch_valid (o_fetch_valid),
        .i_fetch_ready (i_fetch_ready),
        .i_op_valid    (i_op_valid),
        .o_op_ready    (o_op_ready),
        .i_op          (i_op),
        .i_target      (i_target),
        .o_halted      (o_halted),
        .o_stack_err   (o_stack_err),
        .o_wrap_trap   (o_wrap_trap)
    );

    always #5 i_clk = ~i_clk;

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        test_count++;
        if (got !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic doReset();
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
    endtask

    // One fetch handshake followed by one decoded op.
    task automatic applyStimulus(input logic [2:0] op, input logic [15:0] target);
        i_fetch_ready = 1'b1;
        step();
        i_fetch_ready = 1'b0;
        i_op          = op;
        i_target      = target;
        i_op_valid    = 1'b1;
        step();
        i_op_valid    = 1'b0;
    endtask

    initial begin
        // 1. Reset state, fetch stall, sequential stepping
        doReset();
        checkOutput("reset_pc", 32'(o_pc), 32'h0000);
        checkOutput("reset_fetch_valid", 32'(o_fetch_valid), 32'd1);
        checkOutput("reset_op_ready", 32'(o_op_ready), 32'd0);
        checkOutput("reset_halted", 32'(o_halted), 32'd0);
        checkOutput("reset_stack_err", 32'(o_stack_err), 32'd0);
        checkOutput("reset_wrap_trap", 32'(o_wrap_trap), 32'd0);
        for (int k = 0; k < 5; k++) step();
        checkOutput("stall_pc", 32'(o_pc), 32'h0000);
        checkOutput("stall_fetch_valid", 32'(o_fetch_valid), 32'd1);

        i_fetch_ready = 1'b1;
        step();
        i_fetch_ready = 1'b0;
        checkOutput("decode_op_ready", 32'(o_op_ready), 32'd1);
        checkOutput("decode_fetch_valid", 32'(o_fetch_valid), 32'd0);
        step();
        step();
        checkOutput("decode_idle_op_ready", 32'(o_op_ready), 32'd1);
        checkOutput("decode_idle_pc", 32'(o_pc), 32'h0000);
        i_op = OP_NEXT; i_op_valid = 1'b1;
        step();
        i_op_valid = 1'b0;
        checkOutput("next_1", 32'(o_pc), 32'h0001);
        checkOutput("next_1_fetch_valid", 32'(o_fetch_valid), 32'd1);
        applyStimulus(OP_NEXT, 16'h0000);
        checkOutput("next_2", 32'(o_pc), 32'h0002);
        applyStimulus(OP_NEXT, 16'h0000);
        checkOutput("next_3", 32'(o_pc), 32'h0003);

        // 2. Branches and PREV
        applyStimulus(OP_JUMP, 16'h0010);
        checkOutput("jump_10", 32'(o_pc), 32'h0010);
        applyStimulus(OP_BRANCH, 16'hFFF8);
        checkOutput("branch_back", 32'(o_pc), 32'h0008);
        applyStimulus(OP_BRANCH, 16'h0020);
        checkOutput("branch_fwd", 32'(o_pc), 32'h0028);
        applyStimulus(OP_PREV, 16'h0000);
        checkOutput("prev", 32'(o_pc), 32'h0027);
        applyStimulus(OP_HOLD, 16'h1234);
        checkOutput("hold", 32'(o_pc), 32'h0027);
        applyStimulus(OP_RSVD, 16'h1234);
        checkOutput("reserved", 32'(o_pc), 32'h0027);

        // 3. Call / return nesting and overflow
        applyStimulus(OP_JUMP, 16'h0005);
        applyStimulus(OP_CALL, 16'h1000);
        checkOutput("call_1", 32'(o_pc), 32'h1000);
        applyStimulus(OP_CALL, 16'h2000);
        checkOutput("call_2", 32'(o_pc), 32'h2000);
        applyStimulus(OP_RET, 16'h0000);
        checkOutput("ret_1", 32'(o_pc), 32'h1001);
        applyStimulus(OP_RET, 16'h0000);
        checkOutput("ret_2", 32'(o_pc), 32'h0006);
        checkOutput("ret_stack_err", 32'(o_stack_err), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(OP_CALL, 16'(k * 16'h0100));
            checkOutput("nest_call", 32'(o_pc), 32'(k * 16'h0100));
        end
        checkOutput("nest_no_err", 32'(o_stack_err), 32'd0);
        applyStimulus(OP_CALL, 16'h0500);
        checkOutput("overflow_pc", 32'(o_pc), 32'h0400);
        checkOutput("overflow_err", 32'(o_stack_err), 32'd1);
        checkOutput("overflow_halted", 32'(o_halted), 32'd1);
        checkOutput("halt_fetch_valid", 32'(o_fetch_valid), 32'd0);
        checkOutput("halt_op_ready", 32'(o_op_ready), 32'd0);
        applyStimulus(OP_JUMP, 16'h7777);
        checkOutput("halt_frozen_pc", 32'(o_pc), 32'h0400);
        checkOutput("halt_stays", 32'(o_halted), 32'd1);

        // 4. Underflow after reset, then recovery through reset
        doReset();
        applyStimulus(OP_RET, 16'h0000);
        checkOutput("underflow_err", 32'(o_stack_err), 32'd1);
        checkOutput("underflow_halted", 32'(o_halted), 32'd1);
        checkOutput("underflow_pc", 32'(o_pc), 32'h0000);
        doReset();
        checkOutput("recover_pc", 32'(o_pc), 32'h0000);
        checkOutput("recover_err", 32'(o_stack_err), 32'd0);
        checkOutput("recover_halted", 32'(o_halted), 32'd0);
        checkOutput("recover_fetch_valid", 32'(o_fetch_valid), 32'd1);

        // 5. Wrap behaviour; a BRANCH wrap is never trapped
        applyStimulus(OP_JUMP, 16'hFFFF);
        applyStimulus(OP_BRANCH, 16'h0002);
        checkOutput("branch_wrap", 32'(o_pc), 32'h0001);
        checkOutput("branch_wrap_halted", 32'(o_halted), 32'd0);
        applyStimulus(OP_JUMP, 16'hFFFF);
        checkOutput("jump_ffff", 32'(o_pc), 32'hFFFF);
        applyStimulus(OP_NEXT, 16'h0000);
`ifdef PC_WRAP_TRAP_EN
        checkOutput("wrap_next_pc", 32'(o_pc), 32'hFFFF);
        checkOutput("wrap_next_trap", 32'(o_wrap_trap), 32'd1);
        checkOutput("wrap_next_halted", 32'(o_halted), 32'd1);
        doReset();
        checkOutput("wrap_trap_cleared", 32'(o_wrap_trap), 32'd0);
        applyStimulus(OP_PREV, 16'h0000);
        checkOutput("wrap_prev_pc", 32'(o_pc), 32'h0000);
        checkOutput("wrap_prev_trap", 32'(o_wrap_trap), 32'd1);
        checkOutput("wrap_prev_halted", 32'(o_halted), 32'd1);
`else
        checkOutput("wrap_next_pc", 32'(o_pc), 32'h0000);
        checkOutput("wrap_next_trap", 32'(o_wrap_trap), 32'd0);
        checkOutput("wrap_next_halted", 32'(o_halted), 32'd0);
        applyStimulus(OP_PREV, 16'h0000);
        checkOutput("wrap_prev_pc", 32'(o_pc), 32'hFFFF);
        checkOutput("wrap_prev_trap", 32'(o_wrap_trap), 32'd0);
`endif

        // 6. Reset in DECODE wins over a pending JUMP
        doReset();
        applyStimulus(OP_NEXT, 16'h0000);
        i_fetch_ready = 1'b1;
        step();
        i_fetch_ready = 1'b0;
        checkOutput("pre_reset_decode", 32'(o_op_ready), 32'd1);
        i_op = OP_JUMP; i_target = 16'h4000; i_op_valid = 1'b1; i_rst = 1'b1;
        step();
        i_op_valid = 1'b0; i_rst = 1'b0;
        checkOutput("rst_decode_pc", 32'(o_pc), 32'h0000);
        checkOutput("rst_decode_fetch_valid", 32'(o_fetch_valid), 32'd1);
        checkOutput("rst_decode_op_ready", 32'(o_op_ready), 32'd0);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-counter controller for the 16-bit CPU. It owns the PC register and sequences the up/down incrementer and the 16-bit adder to produce the next fetch address. Operations are step forward, step back, absolute jump, relative branch, call and return. A small return-address stack is included, and a valid/ready handshake sits on both the fetch side and the decode side.

Parameters:
WIDTH, 16, PC and target width in bits.
STACK_DEPTH, 4, return-address stack entries (power of two, 2..16).
RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
i_clk  input  1  clock; all state updates on rising edge.
i_rst  input  1  synchronous reset, active-high.
o_pc  output  WIDTH  current fetch address.
o_fetch_valid  output  1  o_pc is valid for instruction fetch.
i_fetch_ready  input  1  memory accepts o_pc this cycle.
i_op_valid  input  1  decode presents an operation.
o_op_ready  output  1  sequencer accepts an operation this cycle.
i_op  input  3  0 NEXT, 1 PREV, 2 JUMP, 3 BRANCH, 4 CALL, 5 RET, 6 HOLD, 7 reserved.
i_target  input  WIDTH  absolute address (JUMP/CALL) or signed two's-complement offset (BRANCH).
o_halted  output  1  sequencer in HALT.
o_stack_err  output  1  sticky: stack overflow/underflow occurred.
o_wrap_trap  output  1  sticky wrap trap (see Optional Feature).

Behaviour:
- Reset (i_rst high at an edge, from any state, including mid-handshake):
  - o_pc=RESET_PC; state=FETCH; stack pointer=0; o_stack_err=0; o_wrap_trap=0; o_halted=0.
  - Next cycle: o_fetch_valid=1, o_op_ready=0.
- States: FETCH, DECODE, HALT.
- FETCH:
  - o_fetch_valid=1, o_op_ready=0.
  - o_pc is held stable until i_fetch_ready=1.
  - The accepting edge moves to DECODE.
- DECODE:
  - o_fetch_valid=0, o_op_ready=1.
  - With i_op_valid=0: no change.
  - With i_op_valid=1, at that edge:
    - NEXT: pc+1.
    - PREV: pc-1.
    - JUMP: pc=i_target.
    - BRANCH: pc=pc+i_target (signed, mod 2^WIDTH).
    - CALL: push pc+1; pc=i_target.
    - RET: pop into pc.
    - HOLD: pc unchanged.
    - Reserved (7): treated as HOLD.
  - Then go to FETCH, except the error cases below.
  - Exactly one op is accepted per fetch; the op-to-new-fetch latency is 1 cycle.
- Arithmetic:
  - All results are modulo 2^WIDTH.
  - NEXT/PREV use the incrementer direction bit (1 = up).
  - BRANCH uses the full adder with cin=0.
- Stack:
  - LIFO, STACK_DEPTH entries.
  - CALL on full stack: no push, pc unchanged, o_stack_err←1, state→HALT.
  - RET on empty stack: pc unchanged, o_stack_err←1, state→HALT.
- HALT:
  - o_halted=1, o_fetch_valid=0, o_op_ready=0.
  - o_pc frozen.
  - Only i_rst exits HALT.
- Sticky flags clear only on reset.

Optional Feature:
PC_WRAP_TRAP_EN.
- Defined:
  - NEXT at pc=max (all ones) or PREV at pc=0: pc unchanged, o_wrap_trap←1, state→HALT.
  - BRANCH wrap is not trapped.
- Undefined:
  - NEXT/PREV wrap silently (0xFFFF→0x0000, 0x0000→0xFFFF).
  - o_wrap_trap is tied 0.
  - The port remains present.

Test Plan:
1. Reset, then 3× (fetch accept, op NEXT) → o_pc sequence 0x0000, 0x0001, 0x0002, 0x0003; o_fetch_valid held with i_fetch_ready=0 for 5 cycles keeps o_pc=0x0000.
2. pc=0x0010, BRANCH i_target=0xFFF8 → 0x0008; then BRANCH 0x0020 → 0x0028; then PREV → 0x0027.
3. CALL 0x1000 from pc=0x0005, CALL 0x2000 from 0x1000, RET → 0x1001, RET → 0x0006; STACK_DEPTH+1 nested CALLs → o_stack_err=1, o_halted=1, o_pc frozen at last target.
4. RET with empty stack after reset → o_stack_err=1, halt; then assert i_rst → o_pc=0x0000, flags 0, o_fetch_valid=1.
5. JUMP 0xFFFF then NEXT → macro undefined: o_pc=0x0000, o_wrap_trap=0; macro defined: o_pc=0xFFFF, o_wrap_trap=1, o_halted=1.
6. i_rst asserted in DECODE with i_op_valid=1/JUMP 0x4000 → op ignored, o_pc=RESET_PC.
